// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the RAM port-A arbiter: FSM state encodings and
// the full-word byte-lane select used by fill writes.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] SEL_WORD = 4'b1111;

endpackage

// File: rtl/ram_port_arbiter_fill_addr_gen.sv
// fill_addr_gen: address/length/pattern registers for the fill engine.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load            capture base/len/pattern into ptr/rem/pat
//   step            advance after a fill write (ptr+1, rem-1)
//   base,len,pattern  launch values
//   ptr, pat        current write address / data
//   last            current write is the final one (rem == 1)
// Build option: FILL_INC_EN makes pat increment after every write (ramp).
module fill_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic [DATA_WIDTH-1:0] pat,
  output logic                  last
);

  localparam int unsigned REM_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;

  // Next-value logic; ptr wraps naturally modulo 2^ADDR_WIDTH.
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    pat_d = pat_q;
    if (load) begin
      ptr_d = base;
      rem_d = len;
      pat_d = pattern;
    end else if (step) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      rem_d = rem_q - REM_W'(1);
`ifdef FILL_INC_EN
      pat_d = pat_q + DATA_WIDTH'(1);
`else
      pat_d = pat_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      rem_q <= '0;
      pat_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
      pat_q <= pat_d;
    end
  end

  assign ptr  = ptr_q;
  assign pat  = pat_q;
  assign last = (rem_q == REM_W'(1));

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between the CPU MEM stage and a
// pattern fill engine. CPU has priority; a starvation counter forces one
// fill grant after STARVE_LIM consecutive denied cycles.
// Ports:
//   rawclk, rst_n            clock, async active-low reset
//   cpu_*                    CPU request in; cpu_stall/cpu_q/cpu_rvalid out
//   cfg_*                    fill launch/abort and parameters
//   busy, done               fill status (registered)
//   ram_we/sel/addr/d        RAM port A drive (combinational from winner)
//   ram_q                    RAM read data (synchronous)
// Build option: FILL_INC_EN (in fill_addr_gen) turns the fill into a ramp.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                  rawclk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_sel,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_d,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_q,
  output logic                  cpu_rvalid,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [3:0]            ram_sel,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rvalid_d;
  logic [3:0]            sel_hold_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] d_hold_q;

  logic                  fill_wins;
  logic                  cpu_grant;
  logic                  fill_load;
  logic                  fill_step;
  logic [ADDR_WIDTH-1:0] fill_ptr;
  logic [DATA_WIDTH-1:0] fill_pat;
  logic                  fill_last;

  fill_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fill_addr_gen (
    .clk     (rawclk),
    .rst_n   (rst_n),
    .load    (fill_load),
    .step    (fill_step),
    .base    (cfg_base),
    .len     (cfg_len),
    .pattern (cfg_pattern),
    .ptr     (fill_ptr),
    .pat     (fill_pat),
    .last    (fill_last)
  );

  // Arbitration: CPU wins unless idle or the fill has been starved out.
  always_comb begin
    fill_wins = 1'b0;
    if (state_q == ST_FILL) begin
      fill_wins = (cnt_q == CNT_W'(STARVE_LIM)) | ~cpu_req;
    end
    cpu_grant = cpu_req & ~fill_wins;
  end

  assign cpu_stall = cpu_req & fill_wins;
  assign cpu_q     = ram_q;

  // Fill FSM next state, starvation counter and registered status.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    fill_load = 1'b0;
    fill_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          fill_load = 1'b1;
          state_d   = (cfg_len == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (fill_wins) begin
          fill_step = 1'b1;
          if (fill_last) state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Abort overrides completion: no done pulse even on the last write.
        if (cfg_abort) state_d = ST_IDLE;
        if (state_d != ST_FILL) cnt_d = '0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_FILL);
    done_d   = (state_d == ST_DONE);
    rvalid_d = cpu_grant & ~cpu_we;
  end

  // RAM port drive; address/data/select hold their last values when idle.
  always_comb begin
    ram_we   = 1'b0;
    ram_sel  = sel_hold_q;
    ram_addr = addr_hold_q;
    ram_d    = d_hold_q;
    if (fill_wins) begin
      ram_we   = 1'b1;
      ram_sel  = SEL_WORD;
      ram_addr = fill_ptr;
      ram_d    = fill_pat;
    end else if (cpu_grant) begin
      ram_we   = cpu_we;
      ram_sel  = cpu_sel;
      ram_addr = cpu_addr;
      ram_d    = cpu_d;
    end
  end

  always_ff @(posedge rawclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      sel_hold_q  <= '0;
      addr_hold_q <= '0;
      d_hold_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rvalid_q    <= rvalid_d;
      sel_hold_q  <= ram_sel;
      addr_hold_q <= ram_addr;
      d_hold_q    <= ram_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_rvalid = rvalid_q;

endmodule
